acquire_window_ctrl: RTL
========================

ACQUIRE_WINDOW_CTRL -- requirements
Module: acquire_window_ctrl

Interface
REQ-001 Parameter CNT_W, default 19: width of the window/holdoff counter and of win_len.
REQ-002 Parameter WAVENUM_W, default 16: width of wavenum and lastwavenum.
REQ-003 Parameter FILT_LEN, default 4: consecutive low cycles of the synchronised UART_RX needed to qualify a trigger (range 1..255).
REQ-004 Parameter HOLDOFF_LEN, default 16: minimum post-window dead time in cycles (range 1..2^CNT_W-1).
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 UART_RX  input  1  asynchronous serial line; a low level (start bit) requests an acquisition.
REQ-008 wavenum  input  WAVENUM_W  current waveform number from the ADC path.
REQ-009 win_len  input  CNT_W  window length in cycles; 0 is treated as 1.
REQ-010 free_run  input  1  1 = trigger regardless of wavenum; 0 = at most one window per distinct wavenum.
REQ-011 acquire  output  1  active-low window indicator: 0 during the window, 1 otherwise.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  single-cycle pulse on the last window cycle.
REQ-014 counter  output  CNT_W  live window/holdoff count.
REQ-015 lastwavenum  output  WAVENUM_W  wavenum captured at the end of the last window.

Function
REQ-016 UART_RX shall pass through a 2-flop synchroniser; rx_s denotes its output (2-cycle latency).
REQ-017 FSM states: IDLE, QUAL, WINDOW, HOLDOFF.
REQ-018 IDLE -> QUAL when rx_s==0 and (free_run==1 or wavenum!=lastwavenum); qualification count set to 1.
REQ-019 QUAL: count increments each cycle rx_s==0; at count==FILT_LEN go to WINDOW with counter<=0 and win_len latched into a shadow register; rx_s==1 first returns to IDLE with no side effects.
REQ-020 WINDOW: acquire=0, counter increments by 1 each cycle; a change of win_len, wavenum or free_run mid-window has no effect.
REQ-021 On the cycle counter==shadow_len-1: done=1, lastwavenum<=wavenum, counter<=0, next state HOLDOFF; window length is exactly shadow_len cycles.
REQ-022 HOLDOFF: counter increments and saturates at HOLDOFF_LEN-1; exit to IDLE only when counter==HOLDOFF_LEN-1 and rx_s==1 (a held-low line never retriggers).
REQ-023 acquire is registered: 0 exactly in the cycles the state register holds WINDOW, 1 in all other states.
REQ-024 Counter arithmetic shall be unsigned CNT_W-bit and shall never wrap; the maximum window is 2^CNT_W-1 cycles.
REQ-025 In QUAL and IDLE counter shall read 0.

Reset
REQ-026 While rst==1 at a clock edge: state=IDLE, acquire=1, busy=0, done=0, counter=0, lastwavenum=0, synchroniser flops=1, qualification count=0; this applies even mid-window, with no done pulse.

Configuration
REQ-027 With ACQ_MISSED_CNT_EN defined: extra output missed_cnt (16 bits, reset 0, saturating at 0xFFFF) increments once per falling edge of rx_s seen while busy==1, or in IDLE with free_run==0 and wavenum==lastwavenum.
REQ-028 Without ACQ_MISSED_CNT_EN: the port and its logic are absent; all other behaviour is identical.

Structure
REQ-029 Package acq_pkg shall hold the FSM state enum, default parameter constants (CNT_W=19, WAVENUM_W=16, FILT_LEN=4, HOLDOFF_LEN=16) and the legacy window length constant 18041.
REQ-030 Sub-module acq_rx_sync shall implement the 2-flop synchroniser (reset value 1); everything else is in acquire_window_ctrl.

Verification
REQ-031 win_len=18041, free_run=0, wavenum=5, UART_RX low 10 cycles -> acquire low exactly 18041 cycles starting 1+2+4 cycles after the edge, done once, lastwavenum=5.
REQ-032 Repeat the trigger with wavenum still 5, free_run=0 -> no window; missed_cnt=1 when ACQ_MISSED_CNT_EN is defined.
REQ-033 UART_RX low for 3 cycles (FILT_LEN=4) -> no window, busy returns to 0.
REQ-034 win_len=0 -> a 1-cycle window with done in the same cycle; win_len changed 100->50 mid-window -> the window stays 100 cycles.
REQ-035 UART_RX held low through a 20-cycle window -> HOLDOFF persists until the line goes high, then IDLE; no second window.
REQ-036 rst asserted at counter=500 inside the window -> the next cycle has acquire=1, counter=0, lastwavenum=0, no done pulse.

Source files
------------

// File: rtl/acq_pkg.sv
// Shared types and default constants for the acquisition window controller.
package acq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUAL    = 2'd1,
        ST_WINDOW  = 2'd2,
        ST_HOLDOFF = 2'd3
    } acq_state_e;

    localparam int ACQ_CNT_W          = 19;
    localparam int ACQ_WAVENUM_W      = 16;
    localparam int ACQ_FILT_LEN       = 4;
    localparam int ACQ_HOLDOFF_LEN    = 16;
    // Window length used by the original fixed-length acquisition firmware.
    localparam int ACQ_LEGACY_WIN_LEN = 18041;

endpackage

// File: rtl/acq_rx_sync.sv
// Two-flop synchroniser for the asynchronous UART_RX trigger line; idles high.
module acq_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_async,
    output logic rx_sync
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx_async};
        end
    end

    assign rx_sync = sync_reg[1];

endmodule

// File: rtl/acquire_window_ctrl.sv
// Acquisition window controller: a filtered low level on UART_RX opens a fixed-length
// active-low acquire window followed by a hold-off. Optional ACQ_MISSED_CNT_EN adds missed_cnt.
module acquire_window_ctrl
    import acq_pkg::*;
#(
    parameter int CNT_W       = ACQ_CNT_W,
    parameter int WAVENUM_W   = ACQ_WAVENUM_W,
    parameter int FILT_LEN    = ACQ_FILT_LEN,
    parameter int HOLDOFF_LEN = ACQ_HOLDOFF_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 UART_RX,
    input  logic [WAVENUM_W-1:0] wavenum,
    input  logic [CNT_W-1:0]     win_len,
    input  logic                 free_run,
    output logic                 acquire,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     counter,
    output logic [WAVENUM_W-1:0] lastwavenum
`ifdef ACQ_MISSED_CNT_EN
    ,
    output logic [15:0]          missed_cnt
`endif
);

    localparam logic [7:0]       FILT_MAX = 8'(FILT_LEN);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLDOFF_LEN - 1);

    logic                 rx_s;
    acq_state_e           state_reg, state_next;
    logic [CNT_W-1:0]     counter_reg, counter_next;
    logic [CNT_W-1:0]     shadow_len_reg, shadow_len_next;
    logic [7:0]           qual_cnt_reg, qual_cnt_next;
    logic [WAVENUM_W-1:0] lastwavenum_reg, lastwavenum_next;
    logic                 acquire_reg;
    logic                 last_cycle;

    acq_rx_sync u_rx_sync (
        .clk      (clk),
        .rst      (rst),
        .rx_async (UART_RX),
        .rx_sync  (rx_s)
    );

    // Shadow length is never zero, so this subtraction cannot underflow.
    assign last_cycle = (counter_reg == shadow_len_reg - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            counter_reg     <= '0;
            shadow_len_reg  <= CNT_W'(1);
            qual_cnt_reg    <= '0;
            lastwavenum_reg <= '0;
            acquire_reg     <= 1'b1;
        end else begin
            state_reg       <= state_next;
            counter_reg     <= counter_next;
            shadow_len_reg  <= shadow_len_next;
            qual_cnt_reg    <= qual_cnt_next;
            lastwavenum_reg <= lastwavenum_next;
            acquire_reg     <= (state_next != ST_WINDOW);
        end
    end

    always_comb begin
        state_next       = state_reg;
        counter_next     = counter_reg;
        shadow_len_next  = shadow_len_reg;
        qual_cnt_next    = qual_cnt_reg;
        lastwavenum_next = lastwavenum_reg;
        case (state_reg)
            ST_IDLE: begin
                counter_next  = '0;
                qual_cnt_next = '0;
                if (!rx_s && (free_run || (wavenum != lastwavenum_reg))) begin
                    state_next    = ST_QUAL;
                    qual_cnt_next = 8'd1;
                end
            end
            ST_QUAL: begin
                counter_next = '0;
                if (qual_cnt_reg >= FILT_MAX) begin
                    state_next      = ST_WINDOW;
                    qual_cnt_next   = '0;
                    shadow_len_next = (win_len == '0) ? CNT_W'(1) : win_len;
                end else if (!rx_s) begin
                    qual_cnt_next = qual_cnt_reg + 8'd1;
                end else begin
                    state_next    = ST_IDLE;
                    qual_cnt_next = '0;
                end
            end
            ST_WINDOW: begin
                if (last_cycle) begin
                    state_next       = ST_HOLDOFF;
                    counter_next     = '0;
                    lastwavenum_next = wavenum;
                end else begin
                    counter_next = counter_reg + CNT_W'(1);
                end
            end
            ST_HOLDOFF: begin
                // Saturate, then wait for the line to idle so a held-low RX never retriggers.
                if (counter_reg == HOLD_MAX) begin
                    if (rx_s) begin
                        state_next   = ST_IDLE;
                        counter_next = '0;
                    end
                end else begin
                    counter_next = counter_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next   = ST_IDLE;
                counter_next = '0;
            end
        endcase
    end

    always_comb begin
        busy        = (state_reg != ST_IDLE);
        done        = (state_reg == ST_WINDOW) && last_cycle;
        acquire     = acquire_reg;
        counter     = counter_reg;
        lastwavenum = lastwavenum_reg;
    end

`ifdef ACQ_MISSED_CNT_EN
    logic        rx_s_d_reg;
    logic [15:0] missed_cnt_reg;
    logic        rx_fall;
    logic        ignored;

    assign rx_fall = rx_s_d_reg & ~rx_s;
    assign ignored = busy || ((state_reg == ST_IDLE) && !free_run && (wavenum == lastwavenum_reg));

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s_d_reg     <= 1'b1;
            missed_cnt_reg <= '0;
        end else begin
            rx_s_d_reg <= rx_s;
            if (rx_fall && ignored && (missed_cnt_reg != 16'hFFFF)) begin
                missed_cnt_reg <= missed_cnt_reg + 16'd1;
            end
        end
    end

    assign missed_cnt = missed_cnt_reg;
`endif

endmodule
